chunk_adder: RTL and testbench

CHUNK_ADDER -- requirements
Module: chunk_adder

---
 rtl/chunk_adder.sv | 120 ++++++++++++
 tb/tb_chunk_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/chunk_adder.sv
// Multi-cycle adder that sums CHUNK bits per clock, LSB chunk first.
// Define CHUNK_ADDER_SUB_EN to add the sub input (a + ~b + 1 when sub=1).
module chunk_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CHUNK_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int unsigned NCH  = WIDTH / CHUNK;
   localparam int unsigned CNTW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CSW  = CHUNK + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [WIDTH-1:0]  b_in_c;
   logic              c_in_c;
   logic [CHUNK-1:0]  a_ch_c, b_ch_c;
   logic [CSW-1:0]    ch_sum_c;
   int unsigned       sh_c;
   logic              last_c;

   // Subtraction is folded into the latched operand: store ~b and force carry-in.
`ifdef CHUNK_ADDER_SUB_EN
   assign b_in_c = sub ? ~b : b;
   assign c_in_c = sub | cin;
`else
   assign b_in_c = b;
   assign c_in_c = cin;
`endif

   assign sh_c     = 32'(cnt_q) * CHUNK;
   assign a_ch_c   = CHUNK'(a_q >> sh_c);
   assign b_ch_c   = CHUNK'(b_q >> sh_c);
   assign ch_sum_c = CSW'(a_ch_c) + CSW'(b_ch_c) + CSW'(carry_q);
   assign last_c   = (cnt_q == CNTW'(NCH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b_in_c;
               carry_d = c_in_c;
               s_d     = '0;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // Unwritten s bits are zero, so OR-ing the chunk into place is enough.
            s_d     = s_q | (WIDTH'(ch_sum_c[CHUNK-1:0]) << sh_c);
            carry_d = ch_sum_c[CHUNK];
            cnt_d   = cnt_q + CNTW'(1);
            if (last_c) begin
               state_d = DONE;
               cnt_d   = '0;
               cout_d  = ch_sum_c[CHUNK];
               // Carry into the MSB is a^b^s at that bit.
               ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ ch_sum_c[CHUNK-1] ^ ch_sum_c[CHUNK];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_chunk_adder.sv
// Scoreboard bench for chunk_adder: driver predicts results, negedge monitor checks them.
module tb_chunk_adder;
   localparam int NCH = 4;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        o;
      int          dcyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        start1 = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        busy, done, cout, ovf;
   logic [15:0] s;
   logic        busy1, done1, cout1, ovf1;
   logic [15:0] s1;

   int   cyc = 0;
   int   free_at = 0;
   int   last_acc = -100;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef CHUNK_ADDER_SUB_EN
      .sub(sub),
`endif
      .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
   );

   chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin),
`ifdef CHUNK_ADDER_SUB_EN
      .sub(sub),
`endif
      .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain arithmetic on the full-width operands.
   function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb,
                                  input logic ci, input logic sb, input int dc);
      exp_t        r;
      logic [15:0] bo;
      logic [16:0] full;
      bo     = sb ? ~bb : bb;
      full   = {1'b0, aa} + {1'b0, bo} + 17'(sb ? 1'b1 : ci);
      r.s    = full[15:0];
      r.c    = full[16];
      r.o    = (aa[15] == bo[15]) && (full[15] != aa[15]);
      r.dcyc = dc;
      return r;
   endfunction

   // Called at a negedge; drives one cycle and predicts whether the next edge accepts.
   task automatic drive(input logic st, input logic [15:0] aa, input logic [15:0] bb,
                        input logic ci, input logic sb);
      int e;
      start = st; a = aa; b = bb; cin = ci; sub = sb;
      e = cyc + 1;
      if (st && !rst && e >= free_at) begin
         q.push_back(model(aa, bb, ci, sb, e + NCH));
         last_acc = e;
         free_at  = e + NCH + 1;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", 32'(busy), 32'(cyc >= last_acc && cyc < last_acc + NCH));
         if (cyc == last_acc) chk("s_clear_on_accept", 32'(s), 32'h0);
         if (done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'h0);
            end else begin
               exp_t x;
               x = q.pop_front();
               chk("done_cycle", 32'(cyc), 32'(x.dcyc));
               chk("s", 32'(s), 32'(x.s));
               chk("cout", 32'(cout), 32'(x.c));
               chk("ovf", 32'(ovf), 32'(x.o));
            end
         end else if (q.size() > 0 && q[0].dcyc <= cyc) begin
            chk("missing_done", 32'(done), 32'h1);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_s", 32'(s), 32'h0);
      chk("rst_cout", 32'(cout), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
      rst = 1'b0;

      drive(1'b1, 16'h0001, 16'hFFFF, 1'b0, 1'b0); idle(6);
      drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0); idle(6);
      drive(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0); idle(6);

      // Start while busy is ignored.
      drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      idle(6);

      // Reset during RUN aborts the operation.
      drive(1'b1, 16'h8001, 16'h8003, 1'b0, 1'b0);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      chk("abort_s", 32'(s), 32'h0);
      chk("abort_cout", 32'(cout), 32'h0);
      chk("abort_ovf", 32'(ovf), 32'h0);
      q.delete();
      last_acc = -100;
      free_at  = 0;
      @(negedge clk);
      drive(1'b1, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0);
      rst = 1'b0;
      drive(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0); idle(6);

      // Start held high: back-to-back operations.
      repeat (16) drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      idle(6);

`ifdef CHUNK_ADDER_SUB_EN
      drive(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1); idle(6);
      drive(1'b1, 16'h0007, 16'h0005, 1'b0, 1'b1); idle(6);
`endif

      for (int i = 0; i < 300; i++) begin
         logic sb;
`ifdef CHUNK_ADDER_SUB_EN
         sb = 1'($urandom);
`else
         sb = 1'b0;
`endif
         drive(1'($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom), 1'($urandom), sb);
      end
      idle(NCH + 3);
      chk("queue_drained", 32'(q.size()), 32'h0);

      // Single-chunk instance: done one cycle after acceptance.
      a = 16'h8000; b = 16'h8000; cin = 1'b1; sub = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("c16_busy_run", 32'(busy1), 32'h1);
      chk("c16_done_early", 32'(done1), 32'h0);
      @(negedge clk);
      chk("c16_done", 32'(done1), 32'h1);
      chk("c16_busy_done", 32'(busy1), 32'h0);
      chk("c16_s", 32'(s1), 32'h0001);
      chk("c16_cout", 32'(cout1), 32'h1);
      chk("c16_ovf", 32'(ovf1), 32'h1);
      @(negedge clk);
      chk("c16_done_pulse", 32'(done1), 32'h0);
      chk("c16_s_hold", 32'(s1), 32'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
